load_data_extract: RTL and testbench
====================================

// Module: load_data_extract
// PURPOSE
// - Load-data formatter between the data-bus read channel and writeback in the LSU.
// - Selects the byte/halfword/word lane from a 32-bit bus beat using the low address bits.
// - Sign- or zero-extends the lane per RISC-V load funct3 via a first-match key mux with a default.
// - Registers the result: one-cycle latency, valid-qualified.
// PARAMETERS
// - NR_KEY    5   number of key/data pairs in the load-type mux (lb, lh, lw, lbu, lhu)
// - KEY_LEN   3   key width (funct3)
// - DATA_LEN  32  bus/result width; must be 32
// PORTS
// - clock         in   1   single clock, rising edge
// - reset         in   1   asynchronous, active-low reset
// - in_valid      in   1   rdata beat present (bus rvalid); capture this cycle
// - funct3        in   3   load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
// - addr_lo       in   2   effective address [1:0]
// - rdata         in   32  raw bus read data, little-endian lanes
// - out_valid     out  1   out_data updated last cycle (1-cycle pulse per in_valid)
// - out_data      out  32  extended load result, held until next capture
// - out_miss      out  1   captured funct3 matched no key (out_data forced to 0)
// - out_misalign  out  1   misaligned access flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async assert, sync deassert): out_valid=0, out_data=0, out_miss=0, out_misalign=0.
// - Byte lane: off = addr_lo*8; byte = rdata[off +: 8].
// - Half lane: off = addr_lo[1]*16; half = rdata[off +: 16]; addr_lo[0] ignored (never out of range).
// - lb: sext(byte). lbu: zext(byte). lh: sext(half). lhu: zext(half). lw: rdata unchanged.
// - Key mux: keys compared in order; first match wins; no match -> default 32'h0 and miss=1.
// - Capture: on rising edge with in_valid=1, load out_data, out_miss, out_misalign; out_valid<=1.
// - in_valid=0: out_valid<=0, out_data/out_miss/out_misalign hold.
// - Back-to-back in_valid: a new result every cycle, no bubbles.
// - reset asserted mid-capture: outputs clear immediately, with no clock edge required.
// - Inputs are sampled only at capture; they may be X while in_valid=0.
// CONFIGURATION
// - Macro LOAD_EXT_MISALIGN_CHK_EN.
// - Defined: out_misalign=1 captured when (lh|lhu) and addr_lo[0]=1, or lw and addr_lo!=0.
// - Misaligned data is still produced using the lane rules above.
// - Undefined: out_misalign is constant 0 and no check logic is built; port always present.
// STRUCTURE
// - Shared package: funct3 load-type constants (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100,
//   LHU=3'b101) and DATA_LEN.
// - Sub-module sign_extend (params DATA_WIDTH, OUT_WIDTH): combinational, replicates MSB.
//   Instantiated twice (8->32, 16->32).
// - Key mux (parameterised loop over NR_KEY pairs) lives inline in this block.
// TESTING
// - rdata=32'h876543F1, lb, addr_lo=0 -> next cycle out_data=32'hFFFFFFF1, out_valid=1, out_miss=0.
// - Same rdata, lbu, addr_lo=1 -> 32'h00000043; lb, addr_lo=3 -> 32'hFFFFFF87.
// - Same rdata, lh, addr_lo=2 -> 32'hFFFF8765; lhu, addr_lo=2 -> 32'h00008765; lw -> 32'h876543F1.
// - funct3=3'b011 with in_valid -> out_data=0, out_miss=1; next idle cycle out_valid=0, data held.
// - Capture lw 32'hDEADBEEF, then pull reset low between edges -> outputs 0 at once.
// - Macro defined: lh, addr_lo=1, rdata=32'h876543F1 -> out_misalign=1, out_data=32'h000043F1.
//   Macro undefined: out_misalign=0.

Source files
------------

// File: rtl/load_data_extract_pkg.sv
// Shared definitions for the LSU load-data formatter: load-type funct3 keys and widths.
package load_data_extract_pkg;

    localparam int unsigned DATA_LEN = 32;
    localparam int unsigned KEY_LEN  = 3;
    localparam int unsigned NR_KEY   = 5;

    typedef enum logic [KEY_LEN-1:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

endpackage

// File: rtl/load_data_extract_if.sv
// Read-beat / writeback bundle between the data-bus read channel and the load formatter.
interface load_data_extract_if;
    import load_data_extract_pkg::*;

    logic                in_valid;
    logic [KEY_LEN-1:0]  funct3;
    logic [1:0]          addr_lo;
    logic [DATA_LEN-1:0] rdata;
    logic                out_valid;
    logic [DATA_LEN-1:0] out_data;
    logic                out_miss;
    logic                out_misalign;

    modport master (
        output in_valid, funct3, addr_lo, rdata,
        input  out_valid, out_data, out_miss, out_misalign
    );

    modport slave (
        input  in_valid, funct3, addr_lo, rdata,
        output out_valid, out_data, out_miss, out_misalign
    );

endinterface

// File: rtl/load_data_extract_sign_extend.sv
// Combinational sign extension: replicates the MSB of data_in up to OUT_WIDTH bits.
module sign_extend #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OUT_WIDTH  = 32
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [OUT_WIDTH-1:0]  data_out
);

    always_comb begin
        data_out = {{(OUT_WIDTH-DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
    end

endmodule

// File: rtl/load_data_extract.sv
// Load-data formatter: lane select, funct3 key mux with extension, registered result.
// Optional misalignment flag built only when LOAD_EXT_MISALIGN_CHK_EN is defined.
module load_data_extract
    import load_data_extract_pkg::*;
#(
    parameter int unsigned NR_KEY   = load_data_extract_pkg::NR_KEY,
    parameter int unsigned KEY_LEN  = load_data_extract_pkg::KEY_LEN,
    parameter int unsigned DATA_LEN = load_data_extract_pkg::DATA_LEN
) (
    input logic               clock,
    input logic               reset,
    load_data_extract_if.slave bus
);

    logic [7:0]          byte_lane;
    logic [15:0]         half_lane;
    logic [DATA_LEN-1:0] byte_sext;
    logic [DATA_LEN-1:0] half_sext;
    logic [KEY_LEN-1:0]  keys  [NR_KEY];
    logic [DATA_LEN-1:0] datas [NR_KEY];
    logic [DATA_LEN-1:0] sel_data;
    logic                sel_miss;

    always_comb begin
        byte_lane = bus.rdata[{bus.addr_lo, 3'b000} +: 8];
        half_lane = bus.rdata[{bus.addr_lo[1], 4'b0000} +: 16];
    end

    sign_extend #(.DATA_WIDTH(8), .OUT_WIDTH(DATA_LEN)) u_sext_byte (
        .data_in  (byte_lane),
        .data_out (byte_sext)
    );

    sign_extend #(.DATA_WIDTH(16), .OUT_WIDTH(DATA_LEN)) u_sext_half (
        .data_in  (half_lane),
        .data_out (half_sext)
    );

    always_comb begin
        keys[0]  = LB;
        datas[0] = byte_sext;
        keys[1]  = LH;
        datas[1] = half_sext;
        keys[2]  = LW;
        datas[2] = bus.rdata;
        keys[3]  = LBU;
        datas[3] = {{(DATA_LEN-8){1'b0}}, byte_lane};
        keys[4]  = LHU;
        datas[4] = {{(DATA_LEN-16){1'b0}}, half_lane};
    end

    // First matching key wins; unmatched funct3 falls through to zero data with miss set.
    always_comb begin
        sel_data = '0;
        sel_miss = 1'b1;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (sel_miss && (bus.funct3 == keys[i])) begin
                sel_data = datas[i];
                sel_miss = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_miss  <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out_data <= sel_data;
                bus.out_miss <= sel_miss;
            end
        end
    end

`ifdef LOAD_EXT_MISALIGN_CHK_EN
    logic misalign_c;

    always_comb begin
        misalign_c = (((bus.funct3 == LH) || (bus.funct3 == LHU)) && bus.addr_lo[0])
                   || ((bus.funct3 == LW) && (bus.addr_lo != 2'b00));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.out_misalign <= 1'b0;
        end else if (bus.in_valid) begin
            bus.out_misalign <= misalign_c;
        end
    end
`else
    always_comb begin
        bus.out_misalign = 1'b0;
    end
`endif

endmodule

// File: tb/tb_load_data_extract.sv
// Self-checking bench for load_data_extract against a plain-arithmetic load model.
module tb_load_data_extract;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    load_data_extract_if bus ();

    load_data_extract dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: lanes by shifting, extension by adding the upper fill when the top bit is set.
    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] a,
                                             input logic [31:0] d, output bit miss, output bit mis);
        int unsigned b;
        int unsigned h;
        int unsigned r;
        b = (d >> (int'(a) * 8)) & 32'hFF;
        h = (d >> ((int'(a) / 2) * 16)) & 32'hFFFF;
        miss = 1'b0;
        mis  = 1'b0;
        case (f)
            3'd0: r = (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1: r = (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd2: r = d;
            3'd4: r = b;
            3'd5: r = h;
            default: begin r = 0; miss = 1'b1; end
        endcase
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        mis = ((f == 3'd1 || f == 3'd5) && (a % 2 == 1)) || (f == 3'd2 && a != 0);
`endif
        return r;
    endfunction

    task automatic drive(input logic [2:0] f, input logic [1:0] a, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.funct3   = f;
        bus.addr_lo  = a;
        bus.rdata    = d;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.funct3   = 'x;
        bus.addr_lo  = 'x;
        bus.rdata    = 'x;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.out_valid, bus.out_miss, bus.out_misalign, bus.out_data} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b m=%b ma=%b d=%h want all 0",
                     bus.out_valid, bus.out_miss, bus.out_misalign, bus.out_data);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  tf [7] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010, 3'b011};
        logic [1:0]  ta [7] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
        logic [31:0] te [7] = '{32'hFFFFFFF1, 32'h00000043, 32'hFFFFFF87, 32'hFFFF8765,
                                32'h00008765, 32'h876543F1, 32'h00000000};
        bit          tm [7] = '{0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            drive(tf[i], ta[i], 32'h876543F1);
            step();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== te[i] || bus.out_miss !== tm[i]
                || bus.out_misalign !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_%0d: got v=%b d=%h miss=%b ma=%b want v=1 d=%h miss=%b ma=0",
                         i, bus.out_valid, bus.out_data, bus.out_miss, bus.out_misalign, te[i], tm[i]);
            end
        end
    endtask

    task automatic test_idle_hold();
        idle();
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_miss !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_hold: got v=%b d=%h miss=%b want v=0 d=00000000 miss=1",
                     bus.out_valid, bus.out_data, bus.out_miss);
        end
    endtask

    task automatic test_misalign();
        bit exp_mis;
`ifdef LOAD_EXT_MISALIGN_CHK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        drive(3'b001, 2'd1, 32'h876543F1);
        step();
        n_checks++;
        if (bus.out_data !== 32'h000043F1 || bus.out_misalign !== exp_mis || bus.out_miss !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_lh: got d=%h ma=%b miss=%b want d=000043f1 ma=%b miss=0",
                     bus.out_data, bus.out_misalign, bus.out_miss, exp_mis);
        end
        idle();
        step();
    endtask

    task automatic test_async_reset();
        drive(3'b010, 2'd0, 32'hDEADBEEF);
        step();
        n_checks++;
        if (bus.out_data !== 32'hDEADBEEF || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre: got d=%h v=%b want d=deadbeef v=1", bus.out_data, bus.out_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_miss, bus.out_misalign, bus.out_data} !== 35'd0) begin
            n_fail++;
            $display("FAIL async_clear: got v=%b m=%b ma=%b d=%h want all 0",
                     bus.out_valid, bus.out_miss, bus.out_misalign, bus.out_data);
        end
        idle();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic [31:0] exp_data = '0;
        bit          exp_miss = 1'b0;
        bit          exp_mis  = 1'b0;
        bit          exp_v;
        bit          m;
        bit          ma;
        logic [31:0] r;
        logic [2:0]  f;
        logic [1:0]  a;
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            exp_v = ($urandom_range(0, 3) != 0);
            if (exp_v) begin
                f = 3'($urandom_range(0, 7));
                a = 2'($urandom_range(0, 3));
                d = $urandom;
                drive(f, a, d);
                r = ref_load(f, a, d, m, ma);
                exp_data = r;
                exp_miss = m;
                exp_mis  = ma;
            end else begin
                idle();
            end
            step();
            n_checks++;
            if (bus.out_valid !== exp_v || bus.out_data !== exp_data || bus.out_miss !== exp_miss
                || bus.out_misalign !== exp_mis) begin
                n_fail++;
                $display("FAIL random_%0d: got v=%b d=%h miss=%b ma=%b want v=%b d=%h miss=%b ma=%b",
                         i, bus.out_valid, bus.out_data, bus.out_miss, bus.out_misalign,
                         exp_v, exp_data, exp_miss, exp_mis);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        idle();
        #12;
        test_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        test_reset();
        test_directed();
        test_idle_hold();
        test_misalign();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
